// File: rtl/harmonic_weighter.sv
// harmonic_weighter
//
// Mixes the fundamental (h1) and the 2nd/3rd harmonic (h2/h3) sample streams
// into one signed 16-bit sample. The gain profile comes from the weight code.
// Gains are 5-bit unsigned coefficients in sixteenths.
//
// Build option:
//   HW_RAMP_EN  defined   -> after each accepted sample, each coefficient steps
//                            by at most 1 toward its target. This avoids clicks.
//               undefined -> coefficients load their targets on every accepted
//                            sample. That sample already uses the new profile.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   weight      gain profile code: 0/3 = (16,0,0), 1 = (8,4,4), 2 = (4,6,6)
//   in_valid    one-cycle pulse; h1/h2/h3 (and weight) are sampled this cycle
//   h1, h2, h3  signed input samples
//   sample_out  signed weighted sample; held between updates
//   out_valid   one-cycle pulse, two cycles after in_valid
module harmonic_weighter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  weight,
  input  logic        in_valid,
  input  logic [15:0] h1,
  input  logic [15:0] h2,
  input  logic [15:0] h3,
  output logic [15:0] sample_out,
  output logic        out_valid
);

  localparam logic [4:0] CoefUnity = 5'd16;
  localparam logic [4:0] CoefZero  = 5'd0;

  // One step toward the target, or hold if already there.
  function automatic logic [4:0] step_toward(input logic [4:0] cur, input logic [4:0] tgt);
    if (cur < tgt) begin
      return cur + 5'd1;
    end else if (cur > tgt) begin
      return cur - 5'd1;
    end else begin
      return cur;
    end
  endfunction

  // The unsigned coefficient times the signed sample, computed at 23 bits.
  // The coefficient is zero-extended so it stays non-negative.
  function automatic logic signed [22:0] weigh(input logic [4:0] c, input logic [15:0] h);
    logic signed [22:0] c_ext;
    logic signed [22:0] h_ext;
    c_ext = $signed({18'd0, c});
    h_ext = $signed({{7{h[15]}}, h});
    return c_ext * h_ext;
  endfunction

  // Coefficient registers.
  logic [4:0] c1_q, c1_d;
  logic [4:0] c2_q, c2_d;
  logic [4:0] c3_q, c3_d;

  // Target profile decoded from weight.
  logic [4:0] t1, t2, t3;
  // Coefficients applied to the sample accepted this cycle.
  logic [4:0] m1, m2, m3;

  // Pipeline stage 1 (products) and stage 2 (output).
  logic signed [22:0] p1_q, p1_d;
  logic signed [22:0] p2_q, p2_d;
  logic signed [22:0] p3_q, p3_d;
  logic               v1_q, v1_d;
  logic [15:0]        sample_q, sample_d;
  logic               out_valid_q, out_valid_d;

  logic signed [22:0] acc;
  logic signed [22:0] acc_shr;

  always_comb begin
    t1 = CoefUnity;
    t2 = CoefZero;
    t3 = CoefZero;
    case (weight)
      2'd1: begin
        t1 = 5'd8;
        t2 = 5'd4;
        t3 = 5'd4;
      end
      2'd2: begin
        t1 = 5'd4;
        t2 = 5'd6;
        t3 = 5'd6;
      end
      default: begin
        t1 = CoefUnity;
        t2 = CoefZero;
        t3 = CoefZero;
      end
    endcase
  end

  always_comb begin
    c1_d = c1_q;
    c2_d = c2_q;
    c3_d = c3_q;
`ifdef HW_RAMP_EN
    // Mix with the current coefficients, then step them toward the target.
    m1 = c1_q;
    m2 = c2_q;
    m3 = c3_q;
    if (in_valid) begin
      c1_d = step_toward(c1_q, t1);
      c2_d = step_toward(c2_q, t2);
      c3_d = step_toward(c3_q, t3);
    end
`else
    // No ramp: the sample that carries a new weight already uses its profile.
    m1 = t1;
    m2 = t2;
    m3 = t3;
    if (in_valid) begin
      c1_d = t1;
      c2_d = t2;
      c3_d = t3;
    end
`endif
  end

  // Stage 1: register products only for accepted samples.
  always_comb begin
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    v1_d = in_valid;
    if (in_valid) begin
      p1_d = weigh(m1, h1);
      p2_d = weigh(m2, h2);
      p3_d = weigh(m3, h3);
    end
  end

  // Stage 2: sum, scale by 1/16, saturate.
  // The three-term sum is at most 3 * 16 * 2^15 in magnitude, which fits in 23 bits.
  always_comb begin
    acc         = p1_q + p2_q + p3_q;
    acc_shr     = acc >>> 4;
    sample_d    = sample_q;
    out_valid_d = v1_q;
    if (v1_q) begin
      if (acc_shr > 23'sd32767) begin
        sample_d = 16'h7fff;
      end else if (acc_shr < -23'sd32768) begin
        sample_d = 16'h8000;
      end else begin
        sample_d = acc_shr[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_q        <= CoefUnity;
      c2_q        <= CoefZero;
      c3_q        <= CoefZero;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      v1_q        <= 1'b0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      v1_q        <= v1_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = out_valid_q;

endmodule

// File: doc/harmonic_weighter.md
# harmonic_weighter

Consumer of the 2-bit weight code produced by the weight-select FSM. Mixes the fundamental and two harmonic sample streams from the note generator into one 16-bit sample using the selected gain profile. Gain changes are ramped one step per sample to avoid audible clicks. Sits between the harmonic sample generators and the codec/mixer path.

## Interface
- No parameters; widths are fixed.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- weight  input  2  weight code from the weight-select FSM: 0 = default, 1 = weight1, 2 = weight2, 3 = treated as 0.
- in_valid  input  1  one-cycle pulse; h1/h2/h3 are valid this cycle.
- h1  input  16  signed fundamental sample.
- h2  input  16  signed 2nd-harmonic sample.
- h3  input  16  signed 3rd-harmonic sample.
- sample_out  output  16  signed weighted sample; held between updates.
- out_valid  output  1  one-cycle pulse; sample_out updated this cycle.

## Operation
- Gains c1, c2 and c3 are 5-bit unsigned coefficients in sixteenths (range 0..16).
- Target gain profiles:
  - Weight 0 (and code 3): (16, 0, 0).
  - Weight 1: (8, 4, 4).
  - Weight 2: (4, 6, 6).
- weight is sampled only on cycles where in_valid = 1.
- Mixing:
  - Each accepted sample uses the current coefficient registers.
  - Compute acc = c1·h1 + c2·h2 + c3·h3 at 23 bits, signed.
  - Shift acc right arithmetically by 4.
  - Saturate the result to [-32768, 32767].
- Ramp (HW_RAMP_EN defined):
  - After a sample is accepted, each coefficient steps ±1 toward its target.
  - A coefficient already at its target holds.
  - Coefficients move independently, so their sum may temporarily differ from 16; saturation covers any overshoot.
- A weight change mid-ramp retargets immediately. The ramp continues from the current coefficients, with no restart.
- The coefficients never move without in_valid.

## Timing
- Reset values: sample_out = 0, out_valid = 0, pipeline valid bits = 0, coefficients = (16, 0, 0).
- Pipeline:
  - Stage 1: registers the three products and updates the coefficients.
  - Stage 2: sums, shifts, saturates, and registers sample_out.
- Latency:
  - in_valid at cycle N gives out_valid = 1 at cycle N+2.
  - The output uses the coefficients that held at cycle N.
- Throughput: in_valid may be asserted every cycle. The outputs keep their input order, with no gaps added.
- Reset mid-operation:
  - In-flight samples are discarded; no out_valid follows the reset.
  - Coefficients return to (16, 0, 0) at once, with no ramp.
- In-flight samples are not affected by a weight change.

## Configuration
- HW_RAMP_EN defined: coefficients ramp by at most 1 per accepted sample, as above.
  - Worst case is 12 samples, from weight 0 to weight 2 for c1.
- HW_RAMP_EN undefined: all coefficients load their targets on every accepted sample.
  - The sample that carries the new weight already uses the new profile.
  - Output never saturates from coefficient overshoot.

## Test plan
- Reset, weight=0, h=(1000, 2000, 3000), in_valid pulse → out_valid 2 cycles later, sample_out = 1000; no out_valid on any other cycle.
- weight=1 held, ramp enabled: after ≥8 samples, h=(1000, 2000, 3000) → 1750.
  - Check coefficients (15, 1, 1), (14, 2, 2), … on the preceding samples.
- weight=2 held (ramp done), h=(1600, 1600, 1600) → 1600; h=(-1600, -1600, -1600) → -1600.
- Saturation: switch weight 0→1, feed h=(32767, 32767, 32767).
  - At the 5th sample, coefficients are (12, 4, 4) → 32767.
  - Once ramp completes (8, 4, 4) → 32767; with all h=-32768 → -32768.
- Back-to-back in_valid for 20 cycles with a weight change at cycle 5, then reset asserted at cycle 10:
  - Outputs stop after the reset.
  - The next sample uses (16, 0, 0).
  - weight=3 behaves exactly as weight 0.
- HW_RAMP_EN undefined: weight switched 0→2 together with h=(1600, 0, 0) → 400 on the first sample.
